// File: rtl/seq_divider_16x8_if.sv
// Handshake and operand/result bundle for the 16/8 sequential divider.
// The master launches a division; the slave (the divider) answers with results.
interface seq_divider_16x8_if #(
    parameter int N = 16,
    parameter int M = 8
);
    logic         start;
    logic [N-1:0] dividend;
    logic [M-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [M-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_16x8.sv
// Radix-2 restoring divider: 16-bit unsigned dividend by 8-bit unsigned
// divisor, one quotient bit per clock, start/busy/done handshake.
// Timeline from the start-sampling edge (edge 0): iterations on edges 1..16,
// results and done on edge 17, back to IDLE on edge 18, so a held start
// relaunches every 19 cycles. A zero divisor skips the iterations and
// finishes on edge 1.
module seq_divider_16x8 (
    input  logic              clk,
    input  logic              rst,
    seq_divider_16x8_if.slave bus
);
    localparam int N  = 16;
    localparam int M  = 8;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] COUNT_INIT = CW'(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t        state_reg;
    state_t        state_next;

    // Partial remainder. It is always below the divisor, so 8 bits hold it;
    // the 9th bit only exists transiently in the shifted value below.
    logic [M-1:0]  r_reg;
    logic [N-1:0]  q_reg;
    logic [M-1:0]  d_reg;
    logic [CW-1:0] count_reg;
    logic          zero_reg;

    logic [N-1:0]  quotient_reg;
    logic [M-1:0]  remainder_reg;
    logic          div_by_zero_reg;

    logic [M:0]    r_shift;
    logic [M:0]    trial;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a zero-divisor run enters RUN with count 0 so it
    // leaves after a single busy cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (bus.start) state_next = RUN;
            RUN:  if (count_reg == '0) state_next = FIN;
            FIN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state
    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state_reg)
            RUN: bus.busy = 1'b1;
            FIN: bus.done = 1'b1;
            default: ;
        endcase
    end

    // One restoring step: shift {R,Q} left, try subtracting the divisor
    always_comb begin
        r_shift = {r_reg, q_reg[N-1]};
        trial   = r_shift - {1'b0, d_reg};
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg           <= '0;
            q_reg           <= '0;
            d_reg           <= '0;
            count_reg       <= '0;
            zero_reg        <= 1'b0;
            quotient_reg    <= '0;
            remainder_reg   <= '0;
            div_by_zero_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        q_reg     <= bus.dividend;
                        d_reg     <= bus.divisor;
                        r_reg     <= '0;
                        zero_reg  <= (bus.divisor == '0);
                        count_reg <= (bus.divisor == '0) ? '0 : COUNT_INIT;
                    end
                end
                RUN: begin
                    if (count_reg != '0) begin
                        if (!trial[M]) begin
                            r_reg <= trial[M-1:0];
                            q_reg <= {q_reg[N-2:0], 1'b1};
                        end else begin
                            r_reg <= r_shift[M-1:0];
                            q_reg <= {q_reg[N-2:0], 1'b0};
                        end
                        count_reg <= count_reg - CW'(1);
                    end else if (zero_reg) begin
                        // Q was never shifted, so it still holds the dividend
                        quotient_reg    <= '1;
                        remainder_reg   <= q_reg[M-1:0];
                        div_by_zero_reg <= 1'b1;
                    end else begin
                        quotient_reg    <= q_reg;
                        remainder_reg   <= r_reg;
                        div_by_zero_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient    = quotient_reg;
    assign bus.remainder   = remainder_reg;
    assign bus.div_by_zero = div_by_zero_reg;
endmodule

// File: tb/tb_seq_divider_16x8.sv
// Self-checking bench for seq_divider_16x8: directed cases, start-while-busy,
// mid-run reset, back-to-back launches and a random operand sweep, all
// compared against plain-arithmetic expectations computed here.
module tb_seq_divider_16x8;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    seq_divider_16x8_if bus ();

    seq_divider_16x8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: plain division with the zero-divisor convention
    task automatic model(input logic [15:0] a, input logic [7:0] b,
                         output logic [15:0] q, output logic [7:0] r, output logic z);
        if (b == 8'd0) begin
            q = 16'hFFFF;
            r = a[7:0];
            z = 1'b1;
        end else begin
            q = 16'(int'(a) / int'(b));
            r = 8'(int'(a) % int'(b));
            z = 1'b0;
        end
    endtask

    // Launch one division and wait for done; lat is the edge index (start
    // edge = 0) after which done was seen, or -1 if the bound expired.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                          output int lat, output int busy_n);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        lat    = -1;
        busy_n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.busy === 1'b1) busy_n++;
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.dividend = 16'h0;
        bus.divisor = 8'h0;
        repeat (3) @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        total++; if (bus.quotient !== 16'h0) begin bad++; $display("FAIL reset_q: got %h want 0000", bus.quotient); end
        total++; if (bus.remainder !== 8'h0) begin bad++; $display("FAIL reset_r: got %h want 00", bus.remainder); end
        total++; if (bus.div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz: got %b want 0", bus.div_by_zero); end
        rst = 1'b0;
        $display("reset: busy=%b done=%b q=%h r=%h dbz=%b", bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
    endtask

    task automatic test_directed();
        logic [15:0] da [7] = '{16'hFE01, 16'h03E8, 16'h0005, 16'hFFFF, 16'hFFFF, 16'h1234, 16'h0010};
        logic [7:0]  db [7] = '{8'hFF, 8'd7, 8'd9, 8'h01, 8'hFF, 8'h00, 8'h04};
        logic [15:0] eq;
        logic [7:0]  er;
        logic        ez;
        int lat, bn, elat;
        for (int i = 0; i < 7; i++) begin
            model(da[i], db[i], eq, er, ez);
            elat = (db[i] == 8'd0) ? 1 : 17;
            run_op(da[i], db[i], lat, bn);
            total++; if (lat != elat) begin bad++; $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, elat); end
            total++; if (bn != elat) begin bad++; $display("FAIL directed_busy_cycles[%0d]: got %0d want %0d", i, bn, elat); end
            total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL directed_busy_at_done[%0d]: got %b want 0", i, bus.busy); end
            total++; if (bus.quotient !== eq) begin bad++; $display("FAIL directed_q[%0d]: got %h want %h", i, bus.quotient, eq); end
            total++; if (bus.remainder !== er) begin bad++; $display("FAIL directed_r[%0d]: got %h want %h", i, bus.remainder, er); end
            total++; if (bus.div_by_zero !== ez) begin bad++; $display("FAIL directed_dbz[%0d]: got %b want %b", i, bus.div_by_zero, ez); end
            $display("directed %0d: %h / %h -> q=%h r=%h dbz=%b lat=%0d", i, da[i], db[i], bus.quotient, bus.remainder, bus.div_by_zero, lat);
            @(negedge clk);
            total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL directed_done_pulse[%0d]: got %b want 0", i, bus.done); end
            total++; if (bus.quotient !== eq) begin bad++; $display("FAIL directed_q_hold[%0d]: got %h want %h", i, bus.quotient, eq); end
        end
    endtask

    task automatic test_start_while_busy();
        int done_cnt = 0;
        int done_k = -1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 16'h0064;
        bus.divisor = 8'h0A;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k == 4 || k == 16) begin
                bus.start = 1'b1;
                bus.dividend = 16'($urandom);
                bus.divisor = 8'($urandom_range(1, 255));
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL ignore_done_count: got %0d want 1", done_cnt); end
        total++; if (done_k != 17) begin bad++; $display("FAIL ignore_latency: got %0d want 17", done_k); end
        total++; if (bus.quotient !== 16'd10) begin bad++; $display("FAIL ignore_q: got %h want 000a", bus.quotient); end
        total++; if (bus.remainder !== 8'd0) begin bad++; $display("FAIL ignore_r: got %h want 00", bus.remainder); end
        $display("start_while_busy: dones=%0d q=%h r=%h", done_cnt, bus.quotient, bus.remainder);
    endtask

    task automatic test_reset_mid_run();
        int done_cnt = 0;
        int lat, bn;
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 16'd200;
        bus.divisor = 8'd3;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (k == 7) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL midreset_done: got %b want 0", bus.done); end
        total++; if (bus.quotient !== 16'h0) begin bad++; $display("FAIL midreset_q: got %h want 0000", bus.quotient); end
        total++; if (bus.remainder !== 8'h0) begin bad++; $display("FAIL midreset_r: got %h want 00", bus.remainder); end
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_cnt++;
        end
        total++; if (done_cnt != 0) begin bad++; $display("FAIL midreset_stray_done: got %0d want 0", done_cnt); end
        run_op(16'd200, 8'd3, lat, bn);
        total++; if (lat != 17) begin bad++; $display("FAIL midreset_rerun_latency: got %0d want 17", lat); end
        total++; if (bus.quotient !== 16'd66) begin bad++; $display("FAIL midreset_rerun_q: got %h want 0042", bus.quotient); end
        total++; if (bus.remainder !== 8'd2) begin bad++; $display("FAIL midreset_rerun_r: got %h want 02", bus.remainder); end
        $display("reset_mid_run: stray_dones=%0d rerun q=%h r=%h", done_cnt, bus.quotient, bus.remainder);
    endtask

    task automatic test_back_to_back();
        logic [15:0] qa [$];
        logic [7:0]  qb [$];
        logic [15:0] a, eq;
        logic [7:0]  b, er;
        logic        ez;
        int last_k = -1;
        int ndone = 0;
        @(negedge clk);
        a = 16'($urandom);
        b = 8'($urandom_range(1, 255));
        bus.start = 1'b1;
        bus.dividend = a;
        bus.divisor = b;
        qa.push_back(a);
        qb.push_back(b);
        for (int k = 0; k < 120 && ndone < 5; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                a = qa.pop_front();
                b = qb.pop_front();
                model(a, b, eq, er, ez);
                total++; if (bus.quotient !== eq) begin bad++; $display("FAIL b2b_q[%0d]: got %h want %h", ndone, bus.quotient, eq); end
                total++; if (bus.remainder !== er) begin bad++; $display("FAIL b2b_r[%0d]: got %h want %h", ndone, bus.remainder, er); end
                if (last_k >= 0) begin
                    total++; if (k - last_k != 19) begin bad++; $display("FAIL b2b_period[%0d]: got %0d want 19", ndone, k - last_k); end
                end else begin
                    total++; if (k != 17) begin bad++; $display("FAIL b2b_first_latency: got %0d want 17", k); end
                end
                $display("back_to_back %0d: %h / %h -> q=%h r=%h at edge %0d", ndone, a, b, bus.quotient, bus.remainder, k);
                last_k = k;
                ndone++;
                if (ndone < 5) begin
                    a = 16'($urandom);
                    b = 8'($urandom_range(1, 255));
                    bus.dividend = a;
                    bus.divisor = b;
                    qa.push_back(a);
                    qb.push_back(b);
                end else begin
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        total++; if (ndone != 5) begin bad++; $display("FAIL b2b_count: got %0d want 5", ndone); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        logic [15:0] a, eq;
        logic [7:0]  b, er;
        logic        ez;
        int lat, bn;
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom);
            b = (i % 40 == 0) ? 8'd0 : 8'($urandom);
            model(a, b, eq, er, ez);
            run_op(a, b, lat, bn);
            total++; if (lat != ((b == 8'd0) ? 1 : 17)) begin bad++; $display("FAIL rand_latency[%0d]: got %0d for %h/%h", i, lat, a, b); end
            total++; if (bus.quotient !== eq) begin bad++; $display("FAIL rand_q[%0d]: %h/%h got %h want %h", i, a, b, bus.quotient, eq); end
            total++; if (bus.remainder !== er) begin bad++; $display("FAIL rand_r[%0d]: %h/%h got %h want %h", i, a, b, bus.remainder, er); end
            total++; if (bus.div_by_zero !== ez) begin bad++; $display("FAIL rand_dbz[%0d]: %h/%h got %b want %b", i, a, b, bus.div_by_zero, ez); end
            if (b != 8'd0) begin
                total++;
                if (int'(bus.quotient) * int'(b) + int'(bus.remainder) != int'(a) || bus.remainder >= b) begin
                    bad++;
                    $display("FAIL rand_invariant[%0d]: %h/%h got q=%h r=%h want q*d+r=dividend and r<d", i, a, b, bus.quotient, bus.remainder);
                end
            end
            $display("random %0d: %h / %h -> q=%h r=%h dbz=%b", i, a, b, bus.quotient, bus.remainder, bus.div_by_zero);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.dividend = 16'h0;
        bus.divisor = 8'h0;
        test_reset();
        test_directed();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
